// File: rtl/array_seq_ctrl_if.sv
// Control/status bundle between the systolic-array sequencer and its
// operand source / PE array.
interface array_seq_ctrl_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KW   = 8
);
    logic            start;
    logic            abort;
    logic [KW-1:0]   k_len;
    logic [ROWS-1:0] row_mask;
    logic [COLS-1:0] col_mask;
    logic            feed_ready;
    logic            busy;
    logic            done;
    logic            arr_clr;
    logic            pe_en;
    logic [ROWS-1:0] row_en;
    logic [COLS-1:0] col_en;
    logic [ROWS-1:0] row_feed;
    logic [KW+1:0]   t_idx;

    modport master (
        output start, abort, k_len, row_mask, col_mask, feed_ready,
        input  busy, done, arr_clr, pe_en, row_en, col_en, row_feed, t_idx
    );

    modport slave (
        input  start, abort, k_len, row_mask, col_mask, feed_ready,
        output busy, done, arr_clr, pe_en, row_en, col_en, row_feed, t_idx
    );
endinterface

// File: rtl/array_seq_ctrl.sv
// Tile sequencer for a ROWS x COLS systolic array: clears the array, then
// walks the skewed run index t, gating operand injection per row.
module array_seq_ctrl #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int KW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    array_seq_ctrl_if.slave   bus
);
    localparam int TW = KW + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d, t_end_s;
    logic [KW-1:0]   k_q, k_d;
    logic [ROWS-1:0] rmask_q, rmask_d;
    logic [COLS-1:0] cmask_q, cmask_d;
    logic [ROWS-1:0] row_en_q, row_en_d;
    logic [COLS-1:0] col_en_q, col_en_d;
    logic [ROWS-1:0] win_q, win_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            clr_q, clr_d;
    logic            run_q, run_d;

    // Last run index: the final operand of the bottom row must still cross all columns.
    assign t_end_s = {2'b00, k_q} + TW'(ROWS + COLS - 3);

    // Next-state, run index and tile configuration latch.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        rmask_d = rmask_q;
        cmask_d = cmask_q;
        if (bus.abort) begin
            state_d = S_IDLE;
            t_d     = {TW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_CLEAR;
                        k_d     = bus.k_len;
                        rmask_d = bus.row_mask;
                        cmask_d = bus.col_mask;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLEAR: begin
                    t_d = {TW{1'b0}};
                    if (k_q == {KW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.feed_ready) begin
                        if (t_q == t_end_s) begin
                            state_d = S_DONE;
                            t_d     = {TW{1'b0}};
                        end else begin
                            t_d = t_q + TW'(1);
                        end
                    end else begin
                        t_d = t_q;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    t_d     = {TW{1'b0}};
                end
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state and index.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        clr_d    = (state_d == S_CLEAR);
        run_d    = (state_d == S_RUN);
        row_en_d = {ROWS{1'b0}};
        col_en_d = {COLS{1'b0}};
        win_d    = {ROWS{1'b0}};
        if (run_d) begin
            row_en_d = rmask_d;
            col_en_d = cmask_d;
        end else begin
            row_en_d = {ROWS{1'b0}};
            col_en_d = {COLS{1'b0}};
        end
        // Row r injects operand t-r, so its window is r <= t < r+k_len.
        for (int r = 0; r < ROWS; r++) begin
            if (run_d && rmask_d[r] && (t_d >= TW'(r)) &&
                (t_d < ({2'b00, k_d} + TW'(r)))) begin
                win_d[r] = 1'b1;
            end else begin
                win_d[r] = 1'b0;
            end
        end
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            t_q      <= {TW{1'b0}};
            k_q      <= {KW{1'b0}};
            rmask_q  <= {ROWS{1'b0}};
            cmask_q  <= {COLS{1'b0}};
            row_en_q <= {ROWS{1'b0}};
            col_en_q <= {COLS{1'b0}};
            win_q    <= {ROWS{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            k_q      <= k_d;
            rmask_q  <= rmask_d;
            cmask_q  <= cmask_d;
            row_en_q <= row_en_d;
            col_en_q <= col_en_d;
            win_q    <= win_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
            run_q    <= run_d;
        end
    end

    // A stall must silence the array in the same cycle, so the registered
    // run window is qualified directly by feed_ready.
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.arr_clr  = clr_q;
    assign bus.pe_en    = run_q & bus.feed_ready;
    assign bus.row_en   = row_en_q;
    assign bus.col_en   = col_en_q;
    assign bus.row_feed = win_q & {ROWS{bus.feed_ready}};
    assign bus.t_idx    = t_q;
endmodule

// File: tb/tb_array_seq_ctrl.sv
// Directed bench for array_seq_ctrl with ROWS=COLS=KW=8.
module tb_array_seq_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    array_seq_ctrl_if #(.ROWS(8), .COLS(8), .KW(8)) bus ();

    array_seq_ctrl #(.ROWS(8), .COLS(8), .KW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [37:0] outs_s = {bus.busy, bus.done, bus.arr_clr, bus.pe_en,
                          bus.row_en, bus.col_en, bus.row_feed, bus.t_idx};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [7:0] k, input logic [7:0] rm, input logic [7:0] cm);
        bus.k_len    = k;
        bus.row_mask = rm;
        bus.col_mask = cm;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    initial begin
        int t;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.k_len = 8'd0;
        bus.row_mask = 8'h00;
        bus.col_mask = 8'h00;
        bus.feed_ready = 1'b1;
        #3;
        check_eq("reset_outs", 64'(outs_s), 64'd0);
        #4 rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_eq("post_reset_idle", 64'(bus.busy), 64'd0);
        tick();

        // Full tile, k=4, no stalls.
        start_tile(8'd4, 8'hFF, 8'hFF);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check_eq("a_clr", 64'(bus.arr_clr), 64'd1);
                check_eq("a_clr_busy", 64'(bus.busy), 64'd1);
                check_eq("a_clr_pe", 64'(bus.pe_en), 64'd0);
                check_eq("a_clr_rowen", 64'(bus.row_en), 64'd0);
            end else if (c <= 19) begin
                t = c - 2;
                check_eq("a_t", 64'(bus.t_idx), 64'(t));
                check_eq("a_pe", 64'(bus.pe_en), 64'd1);
                check_eq("a_feed3", 64'(bus.row_feed[3]), 64'((t >= 3) && (t <= 6)));
                check_eq("a_rowen", 64'(bus.row_en), 64'hFF);
                check_eq("a_nodone", 64'(bus.done), 64'd0);
            end else if (c == 20) begin
                check_eq("a_done", 64'(bus.done), 64'd1);
                check_eq("a_done_pe", 64'(bus.pe_en), 64'd0);
                check_eq("a_done_t", 64'(bus.t_idx), 64'd0);
            end else begin
                check_eq("a_idle", 64'(outs_s), 64'd0);
            end
            tick();
        end

        // Same tile with a 3-cycle stall at t=5.
        start_tile(8'd4, 8'hFF, 8'hFF);
        for (int c = 1; c <= 24; c++) begin
            bus.feed_ready = !((c >= 7) && (c <= 9));
            @(negedge clk);
            if (c >= 2 && c <= 22) begin
                t = (c <= 7) ? c - 2 : ((c <= 10) ? 5 : c - 5);
                check_eq("b_t", 64'(bus.t_idx), 64'(t));
                check_eq("b_pe", 64'(bus.pe_en), 64'(!((c >= 7) && (c <= 9))));
                if (c >= 7 && c <= 9) begin
                    check_eq("b_stall_feed", 64'(bus.row_feed), 64'd0);
                end
            end
            check_eq("b_done", 64'(bus.done), 64'(c == 23));
            tick();
        end
        bus.feed_ready = 1'b1;

        // k_len = 0 goes straight from CLEAR to DONE.
        start_tile(8'd0, 8'hFF, 8'hFF);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check_eq("c_clr", 64'(bus.arr_clr), 64'(c == 1));
            check_eq("c_done", 64'(bus.done), 64'(c == 2));
            check_eq("c_busy", 64'(bus.busy), 64'(c <= 2));
            check_eq("c_pe_feed", 64'({bus.pe_en, bus.row_feed}), 64'd0);
            tick();
        end

        // Abort at t=7, then abort beats start, then a fresh start.
        start_tile(8'd4, 8'hFF, 8'hFF);
        for (int c = 1; c <= 9; c++) begin
            if (c == 9) bus.abort = 1'b1;
            @(negedge clk);
            if (c == 9) check_eq("d_t7", 64'(bus.t_idx), 64'd7);
            tick();
        end
        bus.abort = 1'b0;
        @(negedge clk);
        check_eq("d_abort_outs", 64'(outs_s), 64'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("d_no_done", 64'(bus.done), 64'd0);
            tick();
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        check_eq("d_abort_beats_start", 64'(bus.busy), 64'd0);
        tick();
        start_tile(8'd1, 8'hFF, 8'hFF);
        @(negedge clk);
        check_eq("d_restart_clr", 64'(bus.arr_clr), 64'd1);
        tick();
        for (int c = 2; c <= 18; c++) begin
            @(negedge clk);
            check_eq("d_restart_done", 64'(bus.done), 64'(c == 17));
            tick();
        end

        // Partial masks.
        start_tile(8'd2, 8'h0F, 8'h01);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 17) begin
                t = c - 2;
                check_eq("e_rowen", 64'(bus.row_en), 64'h0F);
                check_eq("e_colen", 64'(bus.col_en), 64'h01);
                check_eq("e_feed1", 64'(bus.row_feed[1]), 64'((t == 1) || (t == 2)));
            end
            check_eq("e_feed_hi", 64'(bus.row_feed[7:4]), 64'd0);
            check_eq("e_done", 64'(bus.done), 64'(c == 18));
            tick();
        end

        // Start while busy is ignored; reset mid-RUN clears outputs at once.
        start_tile(8'd4, 8'hFF, 8'hFF);
        for (int c = 1; c <= 5; c++) begin
            if (c == 4) bus.start = 1'b1;
            @(negedge clk);
            check_eq("f_clr", 64'(bus.arr_clr), 64'(c == 1));
            if (c >= 2) check_eq("f_t", 64'(bus.t_idx), 64'(c - 2));
            tick();
            bus.start = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check_eq("f_async_rst", 64'(outs_s), 64'd0);
        #3 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            check_eq("f_rst_release_idle", 64'(bus.busy), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
